// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: takes one transfer command at a time and turns it
// into pipelined NONSEQ/SEQ address phases with overlapping data phases.
// It supports all HBURST types, WRAP address folding and 1 KB restarts
// for undefined-length INCR bursts.
module ahb_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              cmd_done,
  output logic              cmd_err,
  input  logic              Hreadyout,
  input  logic [DATA_W-1:0] Hrdata,
  output logic [ADDR_W-1:0] Haddr,
  output logic [DATA_W-1:0] Hwdata,
  output logic              Hwrite,
  output logic              Hreadyin,
  output logic [1:0]        Htrans,
  output logic [2:0]        Hsize,
  output logic [2:0]        Hburst
);

  // The beat counter must hold both the 16-beat fixed bursts and the longest INCR.
  localparam int CNT_W    = (LEN_W > 5) ? LEN_W : 5;
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR = 3'b001;

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BURST, S_LAST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [2:0]        hburst_q, hburst_d;
  logic              hreadyin_q, hreadyin_d;
  logic [CNT_W-1:0]  beats_left_q, beats_left_d;
  logic [ADDR_W-1:0] wrap_mask_q, wrap_mask_d;
  logic              dphase_q, dphase_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              cmd_err_q, cmd_err_d;

  logic [CNT_W-1:0]  cmd_beats;
  logic [ADDR_W-1:0] cmd_step;
  logic [ADDR_W-1:0] cmd_span;
  logic [ADDR_W-1:0] cmd_wrap_mask;
  logic [ADDR_W-1:0] cmd_last_addr;
  logic              cmd_illegal;
  logic [ADDR_W-1:0] cur_step;
  logic [ADDR_W-1:0] next_addr;

  // Decode the incoming command: beat count, wrap window and legality.
  always_comb begin
    cmd_beats = '0;
    case (cmd_burst)
      3'b000:         cmd_beats = CNT_W'(1);
      3'b001:         cmd_beats = CNT_W'(cmd_len);
      3'b010, 3'b011: cmd_beats = CNT_W'(4);
      3'b100, 3'b101: cmd_beats = CNT_W'(8);
      default:        cmd_beats = CNT_W'(16);
    endcase
    cmd_step      = ADDR_W'(1) << cmd_size;
    cmd_span      = ADDR_W'(cmd_beats) << cmd_size;
    cmd_last_addr = cmd_addr + cmd_span - ADDR_W'(1);
    cmd_wrap_mask = '1;
    if (cmd_burst inside {3'b010, 3'b100, 3'b110}) begin
      cmd_wrap_mask = cmd_span - ADDR_W'(1);
    end
    cmd_illegal = 1'b0;
    if ((cmd_burst == BURST_INCR) && (cmd_len == '0)) begin
      cmd_illegal = 1'b1;
    end
    if (int'(cmd_size) > MAX_SIZE) begin
      cmd_illegal = 1'b1;
    end
    if ((cmd_addr & (cmd_step - ADDR_W'(1))) != '0) begin
      cmd_illegal = 1'b1;
    end
    // WRAP windows are at most 128 bytes and aligned, so only fixed INCR can cross 1 KB.
    if ((cmd_burst inside {3'b011, 3'b101, 3'b111}) &&
        (((cmd_addr ^ cmd_last_addr) >> 10) != '0)) begin
      cmd_illegal = 1'b1;
    end
  end

  // Next beat address; an all-ones mask turns the wrap fold into a plain increment.
  always_comb begin
    cur_step  = ADDR_W'(1) << hsize_q;
    next_addr = (haddr_q & ~wrap_mask_q) | ((haddr_q + cur_step) & wrap_mask_q);
  end

  // Next-state logic for the transfer FSM and all registered bus outputs.
  always_comb begin
    state_d       = state_q;
    haddr_d       = haddr_q;
    htrans_d      = htrans_q;
    hwrite_d      = hwrite_q;
    hsize_d       = hsize_q;
    hburst_d      = hburst_q;
    hreadyin_d    = 1'b1;
    beats_left_d  = beats_left_q;
    wrap_mask_d   = wrap_mask_q;
    dphase_d      = dphase_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    cmd_err_d     = 1'b0;

    if (dphase_q && !hwrite_q && Hreadyout) begin
      rdata_valid_d = 1'b1;
      rdata_d       = Hrdata;
    end

    if (Hreadyout) begin
      dphase_d = (state_q == S_FIRST) || (state_q == S_BURST);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_illegal) begin
            cmd_err_d = 1'b1;
          end else begin
            state_d      = S_FIRST;
            haddr_d      = cmd_addr;
            htrans_d     = TR_NONSEQ;
            hwrite_d     = cmd_write;
            hsize_d      = cmd_size;
            hburst_d     = cmd_burst;
            beats_left_d = cmd_beats - CNT_W'(1);
            wrap_mask_d  = cmd_wrap_mask;
          end
        end
      end
      S_FIRST, S_BURST: begin
        if (Hreadyout) begin
          if (beats_left_q != '0) begin
            state_d      = S_BURST;
            haddr_d      = next_addr;
            htrans_d     = ((hburst_q == BURST_INCR) && (next_addr[9:0] == 10'd0)) ?
                           TR_NONSEQ : TR_SEQ;
            beats_left_d = beats_left_q - CNT_W'(1);
          end else begin
            state_d  = S_LAST;
            htrans_d = TR_IDLE;
          end
        end
      end
      S_LAST: begin
        if (Hreadyout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register every piece of state, clearing all of it on a synchronous reset.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q       <= S_IDLE;
      haddr_q       <= '0;
      htrans_q      <= TR_IDLE;
      hwrite_q      <= 1'b0;
      hsize_q       <= '0;
      hburst_q      <= '0;
      hreadyin_q    <= 1'b0;
      beats_left_q  <= '0;
      wrap_mask_q   <= '0;
      dphase_q      <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      haddr_q       <= haddr_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      hsize_q       <= hsize_d;
      hburst_q      <= hburst_d;
      hreadyin_q    <= hreadyin_d;
      beats_left_q  <= beats_left_d;
      wrap_mask_q   <= wrap_mask_d;
      dphase_q      <= dphase_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // Completion pulses follow Hreadyout in the same cycle, so they stay combinational.
  assign cmd_ready   = Hresetn && hreadyin_q && (state_q == S_IDLE);
  assign wdata_pop   = Hresetn && dphase_q && hwrite_q && Hreadyout;
  assign cmd_done    = Hresetn && (state_q == S_LAST) && Hreadyout;
  assign Hwdata      = (Hresetn && dphase_q && hwrite_q) ? wdata : '0;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign cmd_err     = cmd_err_q;
  assign Haddr       = haddr_q;
  assign Htrans      = htrans_q;
  assign Hwrite      = hwrite_q;
  assign Hsize       = hsize_q;
  assign Hburst      = hburst_q;
  assign Hreadyin    = hreadyin_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed testbench for ahb_burst_master: walks through single, INCR4,
// WRAP4, wait-state, undefined-INCR 1 KB restart, illegal and mid-burst reset cases.
module tb_ahb_burst_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;

  logic              Hclk;
  logic              Hresetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic [2:0]        cmd_burst;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_pop;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              cmd_done;
  logic              cmd_err;
  logic              Hreadyout;
  logic [DATA_W-1:0] Hrdata;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic              Hwrite;
  logic              Hreadyin;
  logic [1:0]        Htrans;
  logic [2:0]        Hsize;
  logic [2:0]        Hburst;

  int          compareCount = 0;
  int          mismatchCount = 0;
  int          popCount = 0;
  bit          popPending = 1'b0;
  logic [31:0] wdBase = 32'h0;

  ahb_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_pop(wdata_pop), .rdata(rdata), .rdata_valid(rdata_valid),
    .cmd_done(cmd_done), .cmd_err(cmd_err),
    .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans), .Hsize(Hsize), .Hburst(Hburst)
  );

  // Free-running 10-unit clock.
  initial begin
    Hclk = 1'b0;
    forever #5 Hclk = ~Hclk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle: advance the write source after a pop, drive slave inputs, then
  // settle just past the falling edge so outputs are sampled mid-cycle.
  task automatic cycleTick(input logic rdy, input logic [DATA_W-1:0] rd);
    @(negedge Hclk);
    if (popPending) begin
      wdata = wdBase + 32'(popCount);
      popPending = 1'b0;
    end
    Hreadyout = rdy;
    Hrdata = rd;
    #1;
    if (wdata_pop === 1'b1) begin
      popCount++;
      popPending = 1'b1;
    end
  endtask

  // Presents one command for a single cycle; returns in the first cycle after acceptance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [2:0] burst, input logic [4:0] len);
    cycleTick(1'b1, '0);
    checkOutput("cmd_ready_before_cmd", 64'(cmd_ready), 64'(1));
    popCount = 0;
    popPending = 1'b0;
    wdata = wdBase;
    cmd_write = wr;
    cmd_addr = addr;
    cmd_size = size;
    cmd_burst = burst;
    cmd_len = len;
    cmd_valid = 1'b1;
    cycleTick(1'b1, '0);
    cmd_valid = 1'b0;
  endtask

  task automatic checkBus(input string tag, input logic [31:0] addr, input logic [1:0] trans);
    checkOutput({tag, "_haddr"}, 64'(Haddr), 64'(addr));
    checkOutput({tag, "_htrans"}, 64'(Htrans), 64'(trans));
  endtask

  task automatic checkWrite(input string tag, input logic [31:0] hwd, input logic pop,
                            input logic done);
    checkOutput({tag, "_hwdata"}, 64'(Hwdata), 64'(hwd));
    checkOutput({tag, "_pop"}, 64'(wdata_pop), 64'(pop));
    checkOutput({tag, "_done"}, 64'(cmd_done), 64'(done));
  endtask

  // Linear sequence of directed steps with hand-computed expectations.
  initial begin
    Hresetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_size = '0;
    cmd_burst = '0;
    cmd_len = '0;
    wdata = '0;
    Hreadyout = 1'b1;
    Hrdata = '0;

    // Reset values
    cycleTick(1'b1, '0);
    cycleTick(1'b1, '0);
    checkBus("rst", 32'h0, 2'b00);
    checkOutput("rst_hreadyin", 64'(Hreadyin), 64'(0));
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    checkOutput("rst_hwrite", 64'(Hwrite), 64'(0));
    checkOutput("rst_rdata", 64'(rdata), 64'(0));
    checkWrite("rst", 32'h0, 1'b0, 1'b0);
    Hresetn = 1'b1;
    cycleTick(1'b1, '0);
    checkOutput("rel_hreadyin", 64'(Hreadyin), 64'(1));

    // Single byte write
    wdBase = 32'h80;
    applyStimulus(1'b1, 32'h8000_0001, 3'd0, 3'b000, 5'd0);
    checkBus("sgl_c0", 32'h8000_0001, 2'b10);
    checkOutput("sgl_hwrite", 64'(Hwrite), 64'(1));
    checkOutput("sgl_cmd_ready", 64'(cmd_ready), 64'(0));
    checkWrite("sgl_c0", 32'h0, 1'b0, 1'b0);
    cycleTick(1'b1, '0);
    checkOutput("sgl_c1_htrans", 64'(Htrans), 64'(0));
    checkWrite("sgl_c1", 32'h80, 1'b1, 1'b1);
    cycleTick(1'b1, '0);
    checkOutput("sgl_idle_ready", 64'(cmd_ready), 64'(1));
    checkOutput("sgl_idle_done", 64'(cmd_done), 64'(0));

    // INCR4 byte write
    wdBase = 32'h1111_0000;
    applyStimulus(1'b1, 32'h8000_0001, 3'd0, 3'b011, 5'd0);
    checkBus("i4_c0", 32'h8000_0001, 2'b10);
    checkWrite("i4_c0", 32'h0, 1'b0, 1'b0);
    cycleTick(1'b1, '0);
    checkBus("i4_c1", 32'h8000_0002, 2'b11);
    checkWrite("i4_c1", 32'h1111_0000, 1'b1, 1'b0);
    cycleTick(1'b1, '0);
    checkBus("i4_c2", 32'h8000_0003, 2'b11);
    checkWrite("i4_c2", 32'h1111_0001, 1'b1, 1'b0);
    cycleTick(1'b1, '0);
    checkBus("i4_c3", 32'h8000_0004, 2'b11);
    checkWrite("i4_c3", 32'h1111_0002, 1'b1, 1'b0);
    cycleTick(1'b1, '0);
    checkOutput("i4_c4_htrans", 64'(Htrans), 64'(0));
    checkWrite("i4_c4", 32'h1111_0003, 1'b1, 1'b1);
    checkOutput("i4_pops", 64'(popCount), 64'(4));

    // WRAP4 halfword read: the 8-byte window at 0x48 folds 0x4C,0x4E,0x48,0x4A
    applyStimulus(1'b0, 32'h8000_004C, 3'd1, 3'b010, 5'd0);
    checkBus("w4_c0", 32'h8000_004C, 2'b10);
    checkOutput("w4_hsize", 64'(Hsize), 64'(1));
    checkOutput("w4_hburst", 64'(Hburst), 64'(2));
    cycleTick(1'b1, 32'hA000_0001);
    checkBus("w4_c1", 32'h8000_004E, 2'b11);
    checkOutput("w4_c1_rv", 64'(rdata_valid), 64'(0));
    cycleTick(1'b1, 32'hA000_0002);
    checkBus("w4_c2", 32'h8000_0048, 2'b11);
    checkOutput("w4_c2_rv", 64'(rdata_valid), 64'(1));
    checkOutput("w4_c2_rdata", 64'(rdata), 64'(32'hA000_0001));
    cycleTick(1'b1, 32'hA000_0003);
    checkBus("w4_c3", 32'h8000_004A, 2'b11);
    checkOutput("w4_c3_rdata", 64'(rdata), 64'(32'hA000_0002));
    cycleTick(1'b1, 32'hA000_0004);
    checkOutput("w4_c4_htrans", 64'(Htrans), 64'(0));
    checkOutput("w4_c4_done", 64'(cmd_done), 64'(1));
    checkOutput("w4_c4_rdata", 64'(rdata), 64'(32'hA000_0003));
    checkOutput("w4_c4_pop", 64'(wdata_pop), 64'(0));
    cycleTick(1'b1, '0);
    checkOutput("w4_c5_rv", 64'(rdata_valid), 64'(1));
    checkOutput("w4_c5_rdata", 64'(rdata), 64'(32'hA000_0004));

    // INCR4 word write with two wait states on the second data phase
    wdBase = 32'h2222_0000;
    applyStimulus(1'b1, 32'h8000_0010, 3'd2, 3'b011, 5'd0);
    checkBus("ws_c0", 32'h8000_0010, 2'b10);
    cycleTick(1'b1, '0);
    checkBus("ws_c1", 32'h8000_0014, 2'b11);
    checkWrite("ws_c1", 32'h2222_0000, 1'b1, 1'b0);
    cycleTick(1'b0, '0);
    checkBus("ws_c2", 32'h8000_0018, 2'b11);
    checkWrite("ws_c2", 32'h2222_0001, 1'b0, 1'b0);
    cycleTick(1'b0, '0);
    checkBus("ws_c3", 32'h8000_0018, 2'b11);
    checkWrite("ws_c3", 32'h2222_0001, 1'b0, 1'b0);
    cycleTick(1'b1, '0);
    checkBus("ws_c4", 32'h8000_0018, 2'b11);
    checkWrite("ws_c4", 32'h2222_0001, 1'b1, 1'b0);
    cycleTick(1'b1, '0);
    checkBus("ws_c5", 32'h8000_001C, 2'b11);
    checkWrite("ws_c5", 32'h2222_0002, 1'b1, 1'b0);
    cycleTick(1'b1, '0);
    checkOutput("ws_c6_htrans", 64'(Htrans), 64'(0));
    checkWrite("ws_c6", 32'h2222_0003, 1'b1, 1'b1);
    checkOutput("ws_pops", 64'(popCount), 64'(4));

    // Undefined INCR word read restarting with NONSEQ at the 1 KB boundary
    applyStimulus(1'b0, 32'h8000_03F8, 3'd2, 3'b001, 5'd4);
    checkBus("u_c0", 32'h8000_03F8, 2'b10);
    checkOutput("u_hburst", 64'(Hburst), 64'(1));
    cycleTick(1'b1, '0);
    checkBus("u_c1", 32'h8000_03FC, 2'b11);
    cycleTick(1'b1, '0);
    checkBus("u_c2", 32'h8000_0400, 2'b10);
    cycleTick(1'b1, '0);
    checkBus("u_c3", 32'h8000_0404, 2'b11);
    cycleTick(1'b1, '0);
    checkOutput("u_c4_htrans", 64'(Htrans), 64'(0));
    checkOutput("u_c4_done", 64'(cmd_done), 64'(1));

    // Illegal commands: misaligned word, oversize, zero-length INCR, INCR4 across 1 KB
    applyStimulus(1'b1, 32'h8000_0002, 3'd2, 3'b000, 5'd0);
    checkOutput("ill_mis_err", 64'(cmd_err), 64'(1));
    checkOutput("ill_mis_htrans", 64'(Htrans), 64'(0));
    cycleTick(1'b1, '0);
    checkOutput("ill_mis_err_off", 64'(cmd_err), 64'(0));
    checkOutput("ill_mis_htrans2", 64'(Htrans), 64'(0));
    applyStimulus(1'b0, 32'h8000_0000, 3'd3, 3'b000, 5'd0);
    checkOutput("ill_size_err", 64'(cmd_err), 64'(1));
    applyStimulus(1'b0, 32'h8000_0000, 3'd2, 3'b001, 5'd0);
    checkOutput("ill_len0_err", 64'(cmd_err), 64'(1));
    applyStimulus(1'b0, 32'h8000_03F8, 3'd2, 3'b011, 5'd0);
    checkOutput("ill_1kb_err", 64'(cmd_err), 64'(1));
    checkOutput("ill_1kb_htrans", 64'(Htrans), 64'(0));

    // Reset asserted in the middle of an INCR8 write
    wdBase = 32'h3333_0000;
    applyStimulus(1'b1, 32'h8000_0100, 3'd2, 3'b101, 5'd0);
    checkOutput("i8_c0_err", 64'(cmd_err), 64'(0));
    checkBus("i8_c0", 32'h8000_0100, 2'b10);
    cycleTick(1'b1, '0);
    checkBus("i8_c1", 32'h8000_0104, 2'b11);
    cycleTick(1'b1, '0);
    checkBus("i8_c2", 32'h8000_0108, 2'b11);
    cycleTick(1'b1, '0);
    Hresetn = 1'b0;
    cycleTick(1'b1, '0);
    checkBus("mrst", 32'h0, 2'b00);
    checkWrite("mrst", 32'h0, 1'b0, 1'b0);
    checkOutput("mrst_hwrite", 64'(Hwrite), 64'(0));
    checkOutput("mrst_hsize", 64'(Hsize), 64'(0));
    checkOutput("mrst_hburst", 64'(Hburst), 64'(0));
    checkOutput("mrst_hreadyin", 64'(Hreadyin), 64'(0));
    checkOutput("mrst_cmd_ready", 64'(cmd_ready), 64'(0));
    Hresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycleTick(1'b1, '0);
      checkOutput("post_rst_done", 64'(cmd_done), 64'(0));
      checkOutput("post_rst_htrans", 64'(Htrans), 64'(0));
    end
    checkOutput("post_rst_ready", 64'(cmd_ready), 64'(1));
    checkOutput("post_rst_hreadyin", 64'(Hreadyin), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
